// File: rtl/nt_level_driver.sv
// -----------------------------------------------------------------------------
// nt_level_driver
//
// Closed-loop command source for an nt_neurotransmitter_level register. On an
// accepted request it latches a target and walks the register's value (fed back
// on `level`) towards it with rate-limited inc/dec strobes, qualifying a strobe
// with `fast` while the remaining distance is large. It reports `done` when the
// level matches the target, or `timeout` after MAX_STEPS strobes. `flush`
// abandons any operation and pulses `setval`.
//
// Ports
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   req      in   1  start request, sampled only while idle
//   target   in   N  target level, latched on an accepted request
//   level    in   N  current value of the driven level register
//   flush    in   1  highest priority: pulse setval and abandon operation
//   inc      out  1  increment strobe
//   dec      out  1  decrement strobe
//   fast     out  1  fast-step qualifier, only high together with inc or dec
//   setval   out  1  set-to-SET_VAL strobe
//   busy     out  1  operation in progress
//   done     out  1  one-cycle pulse, level reached the latched target
//   timeout  out  1  one-cycle pulse, MAX_STEPS strobes issued without success
//
// Every output is a flop; none depends combinationally on an input.
// -----------------------------------------------------------------------------
module nt_level_driver #(
    parameter int N           = 8,
    parameter int FAST_STEP   = 3,
    parameter int FAST_THRESH = 4,
    parameter int TICK_DIV    = 4,
    parameter int MAX_STEPS   = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req,
    input  logic [N-1:0] target,
    input  logic [N-1:0] level,
    input  logic         flush,
    output logic         inc,
    output logic         dec,
    output logic         fast,
    output logic         setval,
    output logic         busy,
    output logic         done,
    output logic         timeout
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(MAX_STEPS + 1);

    localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LIMIT  = SW'(MAX_STEPS);

    // A fast step must never jump past the target, so the threshold is never
    // allowed below the register's fast step size.
    localparam int FAST_THRESH_EFF = (FAST_THRESH < FAST_STEP) ? FAST_STEP : FAST_THRESH;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        STEP,
        SETTLE
    } state_t;

    state_t        state;
    logic [N-1:0]  tgt_q;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] step_cnt;

    logic [N-1:0]  diff;
    logic          fast_next;

    // Unsigned distance between target and level; never wraps.
    always_comb begin
        diff      = (level > tgt_q) ? (level - tgt_q) : (tgt_q - level);
        fast_next = (int'(diff) >= FAST_THRESH_EFF);
    end

    // NOTE: all state and outputs are flops, so every assignment here is
    // non-blocking; blocking ones would make the read order inside this block
    // change behaviour and mismatch between simulation and synthesis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            // NOTE: tgt_q is plain datapath, but it is cheap and keeps the
            // reset state fully defined, so it is cleared with the control.
            tgt_q    <= '0;
            tick_cnt <= '0;
            step_cnt <= '0;
            inc      <= 1'b0;
            dec      <= 1'b0;
            fast     <= 1'b0;
            setval   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            // Strobes and pulses last a single cycle unless re-asserted below.
            inc     <= 1'b0;
            dec     <= 1'b0;
            fast    <= 1'b0;
            setval  <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;

            if (flush) begin
                setval <= 1'b1;
                busy   <= 1'b0;
                state  <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            tgt_q    <= target;
                            tick_cnt <= TICK_RELOAD;
                            step_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= WAIT_TICK;
                        end
                    end

                    WAIT_TICK: begin
                        if (tick_cnt != '0) begin
                            tick_cnt <= tick_cnt - 1'b1;
                        end else if (level == tgt_q) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            // The strobe flops are loaded here so they are
                            // high for exactly the STEP cycle.
                            inc   <= (level < tgt_q);
                            dec   <= (level > tgt_q);
                            fast  <= fast_next;
                            state <= STEP;
                        end
                    end

                    STEP: begin
                        step_cnt <= step_cnt + 1'b1;
                        state    <= SETTLE;
                    end

                    SETTLE: begin
                        // The level register has absorbed the strobe by now;
                        // the next comparison happens after a fresh tick wait.
                        if (step_cnt == STEP_LIMIT) begin
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            tick_cnt <= TICK_RELOAD;
                            state    <= WAIT_TICK;
                        end
                    end

                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nt_level_driver.sv
// -----------------------------------------------------------------------------
// tb_nt_level_driver
//
// Two drivers share req/target/flush: instance 0 uses MAX_STEPS=64, instance 1
// uses MAX_STEPS=4. Each drives its own modelled level register (saturating,
// step 1 or FAST_STEP, SET_VAL on setval, optional hold to freeze it).
// A timeline model predicts every output of both instances each cycle: after
// acceptance at edge k, decisions happen at edge k+TICK_DIV and then every
// TICK_DIV+2 edges; a decision either ends the operation (done) or emits one
// strobe. Directed scenarios pin the model with literal timings.
// -----------------------------------------------------------------------------
module tb_nt_level_driver;

    localparam int N           = 8;
    localparam int FAST_STEP   = 3;
    localparam int FAST_THRESH = 4;
    localparam int TICK_DIV    = 4;
    localparam logic [7:0] SET_VAL = 8'h80;

    typedef struct packed {
        logic inc;
        logic dec;
        logic fast;
        logic setval;
        logic busy;
        logic done;
        logic timeout;
    } out_t;

    logic         clk;
    logic         rst_n;
    logic         req;
    logic         flush;
    logic [N-1:0] target;
    logic [N-1:0] lvl [2] = '{8'd0, 8'd0};
    logic         inc_o [2];
    logic         dec_o [2];
    logic         fast_o [2];
    logic         setval_o [2];
    logic         busy_o [2];
    logic         done_o [2];
    logic         timeout_o [2];

    logic         hold [2];
    logic         preset_en;
    logic [N-1:0] preset_val;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    nt_level_driver #(
        .N(N), .FAST_STEP(FAST_STEP), .FAST_THRESH(FAST_THRESH),
        .TICK_DIV(TICK_DIV), .MAX_STEPS(64)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .target(target), .level(lvl[0]),
        .flush(flush), .inc(inc_o[0]), .dec(dec_o[0]), .fast(fast_o[0]),
        .setval(setval_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .timeout(timeout_o[0])
    );

    nt_level_driver #(
        .N(N), .FAST_STEP(FAST_STEP), .FAST_THRESH(FAST_THRESH),
        .TICK_DIV(TICK_DIV), .MAX_STEPS(4)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .target(target), .level(lvl[1]),
        .flush(flush), .inc(inc_o[1]), .dec(dec_o[1]), .fast(fast_o[1]),
        .setval(setval_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .timeout(timeout_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_tests++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req_v);
        end
    endtask

    function automatic int max_steps(input int i);
        return (i == 0) ? 64 : 4;
    endfunction

    function automatic out_t dut_out(input int i);
        out_t o;
        o.inc     = inc_o[i];
        o.dec     = dec_o[i];
        o.fast    = fast_o[i];
        o.setval  = setval_o[i];
        o.busy    = busy_o[i];
        o.done    = done_o[i];
        o.timeout = timeout_o[i];
        return o;
    endfunction

    function automatic logic [7:0] moved(input logic [7:0] v, input logic up, input logic f);
        int s;
        int r;
        s = f ? FAST_STEP : 1;
        r = up ? int'(v) + s : int'(v) - s;
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        return 8'(r);
    endfunction

    // ---------------- reference model ----------------
    out_t         exp_o [2] = '{'0, '0};
    logic         m_active [2] = '{1'b0, 1'b0};
    logic [N-1:0] m_tgt [2];
    int           m_dec_at [2];
    int           m_tout_at [2];
    int           m_steps [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_active[i] = 1'b0;
                exp_o[i]    = '0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                out_t e;
                int   d;
                // level register reacting to the strobes seen last cycle
                if (preset_en)          lvl[i] <= preset_val;
                else if (setval_o[i])   lvl[i] <= SET_VAL;
                else if (!hold[i] && (inc_o[i] || dec_o[i]))
                    lvl[i] <= moved(lvl[i], inc_o[i], fast_o[i]);

                e = '0;
                if (flush) begin
                    e.setval    = 1'b1;
                    m_active[i] = 1'b0;
                end else if (!m_active[i]) begin
                    if (req) begin
                        m_active[i]  = 1'b1;
                        m_tgt[i]     = target;
                        m_steps[i]   = 0;
                        m_dec_at[i]  = cyc + TICK_DIV;
                        m_tout_at[i] = -1;
                        e.busy       = 1'b1;
                    end
                end else if (cyc == m_dec_at[i]) begin
                    if (lvl[i] == m_tgt[i]) begin
                        e.done      = 1'b1;
                        m_active[i] = 1'b0;
                    end else begin
                        d      = int'(m_tgt[i]) - int'(lvl[i]);
                        e.inc  = (d > 0);
                        e.dec  = (d < 0);
                        e.fast = ((d < 0 ? -d : d) >= FAST_THRESH);
                        e.busy = 1'b1;
                        m_steps[i]++;
                        if (m_steps[i] == max_steps(i)) m_tout_at[i] = cyc + 2;
                        else                            m_dec_at[i]  = cyc + TICK_DIV + 2;
                    end
                end else if (cyc == m_tout_at[i]) begin
                    e.timeout   = 1'b1;
                    m_active[i] = 1'b0;
                end else begin
                    e.busy = 1'b1;
                end
                exp_o[i] = e;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++)
            check($sformatf("outs_i%0d_cyc%0d", i, cyc), 32'(dut_out(i)), 32'(exp_o[i]));
    end

    // ---------------- directed-scenario recorder ----------------
    int n_st [2];
    int n_dec [2];
    int st_cyc [2][16];
    int fast_mask [2];
    int n_done [2];
    int done_cyc [2];
    int n_tout [2];
    int busy_rise [2];

    task automatic run_op(input logic [7:0] l0, input logic [7:0] tg, input logic hold1, input int ncyc);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = l0;
        hold[1]    = hold1;
        @(negedge clk);
        preset_en = 1'b0;
        req       = 1'b1;
        target    = tg;
        @(negedge clk);
        req    = 1'b0;
        target = 8'($urandom);
        for (int i = 0; i < 2; i++) begin
            n_st[i] = 0; n_dec[i] = 0; fast_mask[i] = 0;
            n_done[i] = 0; done_cyc[i] = -1; n_tout[i] = 0; busy_rise[i] = -1;
        end
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (busy_o[i] && busy_rise[i] < 0) busy_rise[i] = cyc;
                if (inc_o[i] || dec_o[i]) begin
                    if (n_st[i] < 16) st_cyc[i][n_st[i]] = cyc;
                    if (fast_o[i] && n_st[i] < 31) fast_mask[i] |= (1 << n_st[i]);
                    if (dec_o[i]) n_dec[i]++;
                    n_st[i]++;
                end
                if (done_o[i]) begin n_done[i]++; done_cyc[i] = cyc; end
                if (timeout_o[i]) n_tout[i]++;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic seen;
        rst_n      = 1'b0;
        req        = 1'b0;
        flush      = 1'b0;
        target     = '0;
        hold[0]    = 1'b0;
        hold[1]    = 1'b0;
        preset_en  = 1'b0;
        preset_val = '0;
        repeat (3) @(negedge clk);
        check("reset_state_i0", 32'(dut_out(0)), 32'd0);
        check("reset_state_i1", 32'(dut_out(1)), 32'd0);
        rst_n = 1'b1;

        // Reset asserted while a strobe is high.
        @(negedge clk);
        preset_en = 1'b1; preset_val = 8'd2;
        @(negedge clk);
        preset_en = 1'b0; req = 1'b1; target = 8'd5;
        @(negedge clk);
        req  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (inc_o[0]) seen = 1'b1;
        end
        check("rst_reached_step", 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_i0", 32'(dut_out(0)), 32'd0);
        check("rst_async_i1", 32'(dut_out(1)), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy_after", 32'(busy_o[0]), 32'd0);

        // Slow walk 2 -> 5.
        run_op(8'd2, 8'd5, 1'b0, 45);
        check("slow_strobes",     32'(n_st[0]), 32'd3);
        check("slow_first_delay", 32'(st_cyc[0][0] - busy_rise[0]), 32'(TICK_DIV));
        check("slow_spacing_a",   32'(st_cyc[0][1] - st_cyc[0][0]), 32'd6);
        check("slow_spacing_b",   32'(st_cyc[0][2] - st_cyc[0][1]), 32'd6);
        check("slow_fast_bits",   32'(fast_mask[0]), 32'd0);
        check("slow_done_delay",  32'(done_cyc[0] - st_cyc[0][2]), 32'd6);
        check("slow_done_count",  32'(n_done[0]), 32'd1);
        check("slow_final_level", 32'(lvl[0]), 32'd5);

        // Fast walk 0 -> 10: fast, fast, fast, slow.
        run_op(8'd0, 8'd10, 1'b0, 45);
        check("fast_strobes",     32'(n_st[0]), 32'd4);
        check("fast_bits",        32'(fast_mask[0]), 32'h7);
        check("fast_done_count",  32'(n_done[0]), 32'd1);
        check("fast_final_level", 32'(lvl[0]), 32'd10);
        check("fast_i1_timeout",  32'(n_tout[1]), 32'd1);
        check("fast_i1_no_done",  32'(n_done[1]), 32'd0);

        // Already at target.
        run_op(8'd7, 8'd7, 1'b0, 20);
        check("eq_strobes",    32'(n_st[0]), 32'd0);
        check("eq_done_delay", 32'(done_cyc[0] - busy_rise[0]), 32'(TICK_DIV));
        check("eq_done_count", 32'(n_done[0]), 32'd1);

        // Level frozen at 0 on instance 1: four incs then timeout.
        run_op(8'd0, 8'd9, 1'b1, 45);
        check("tout_strobes",  32'(n_st[1]), 32'd4);
        check("tout_no_dec",   32'(n_dec[1]), 32'd0);
        check("tout_count",    32'(n_tout[1]), 32'd1);
        check("tout_no_done",  32'(n_done[1]), 32'd0);
        check("tout_i0_done",  32'(n_done[0]), 32'd1);
        hold[1] = 1'b0;

        // Flush with req during the tick wait.
        @(negedge clk);
        preset_en = 1'b1; preset_val = 8'd2;
        @(negedge clk);
        preset_en = 1'b0; req = 1'b1; target = 8'd5;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        flush = 1'b1; req = 1'b1; target = 8'd9;
        @(negedge clk);
        flush = 1'b0; req = 1'b0;
        check("flush_setval", 32'(setval_o[0]), 32'd1);
        check("flush_busy",   32'(busy_o[0]), 32'd0);
        @(negedge clk);
        check("flush_setval_end", 32'(setval_o[0]), 32'd0);
        check("flush_no_accept",  32'(busy_o[0]), 32'd0);
        check("flush_level",      32'(lvl[0]), 32'(SET_VAL));

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req    = ($urandom_range(0, 3) == 0);
            target = ($urandom_range(0, 1) == 0) ? 8'(lvl[0] + 8'($urandom_range(0, 12)) - 8'd6)
                                                 : 8'($urandom);
            flush  = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 199) == 0) hold[1] = ~hold[1];
        end
        req = 1'b0; flush = 1'b0; hold[1] = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
